hazard_detection_unit: RTL and testbench
========================================

HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: rst_n  in  1  reset, synchronous and active-low.
REQ-003 SHALL: IdEx_MemRead  in  1  ID/EX instruction is a load.
REQ-004 SHALL: IdEx_MemWrite  in  1  ID/EX instruction is a store.
REQ-005 SHALL: MemWb_MemRead  in  1  MEM/WB instruction is a load.
REQ-006 SHALL: MemRb_Reg_wr_control  in  1  MEM/WB register-write enable.
REQ-007 SHALL: Ctrl_Branch  in  1  branch being resolved in ID/EX.
REQ-008 SHALL: FwdPc  in  1  PC redirect (taken branch/jump).
REQ-009 SHALL: IfIdRs, IfIdRt  in  5 each  IF/ID source registers.
REQ-010 SHALL: IdExRs, IdExRt  in  5 each  ID/EX source registers; IdExRt is also the load destination.
REQ-011 SHALL: ExMemRd, ExMemRs  in  5 each  EX/MEM destination and source registers.
REQ-012 SHALL: MemWbRd, MemWbRt  in  5 each  MEM/WB destination candidates.
REQ-013 SHALL: Stall  out  1  freeze PC and IF/ID, bubble ID/EX.
REQ-014 SHALL: Flush  out  1  discard IF/ID contents.

Function
REQ-015 SHALL: register index 0 never matches (hardwired zero); every compare below requires a nonzero register.
REQ-016 SHALL: load-use hazard H1 = IdEx_MemRead & (IdExRt==IfIdRs | IdExRt==IfIdRt).
REQ-017 SHALL: memory-op hazard H2 = MemWb_MemRead & (IdEx_MemRead | IdEx_MemWrite) & (MemWbRd==IdExRs | MemWbRd==IdExRt).
REQ-018 SHALL: branch hazard H3 = Ctrl_Branch & ((ExMemRd==IdExRs | ExMemRd==IdExRt) | (MemWb_MemRead & (MemWbRt==IdExRs | MemWbRt==IdExRt))).
REQ-019 SHALL: branch writeback hazard H4 = Ctrl_Branch & MemRb_Reg_wr_control & (ExMemRs==MemWbRt).
REQ-020 SHALL: stall_next = (H1|H2|H3|H4) & ~FwdPc; flush_next = FwdPc.
REQ-021 SHALL: FwdPc dominates: simultaneous redirect and hazard yields Flush=1, Stall=0.
REQ-022 SHALL: Stall and Flush are registered: value computed from inputs sampled at edge N appears after edge N, held one cycle; latency exactly 1 cycle.
REQ-023 SHALL: Stall and Flush never both 1 in the same cycle.
REQ-024 SHALL: no other internal state; outputs depend only on previous-cycle inputs.

Reset
REQ-025 SHALL: rst_n=0 at a rising edge forces Stall=0, Flush=0 after that edge, overriding any hazard or FwdPc.
REQ-026 SHALL: reset asserted mid-hazard clears outputs on the next edge; first post-reset edge evaluates inputs normally.

Structure
REQ-027 SHALL: register-index width (5) and the zero-register constant live in the shared pipeline package.
REQ-028 SHALL: a single sub-module reg_match (two 5-bit indices -> equal & nonzero) is instantiated for every compare; the rest is flat.

Verification
REQ-029 SHALL: IdEx_MemRead=1, IdExRt=01011, IfIdRt=01011, all else 0 -> Stall=1, Flush=0 one cycle later.
REQ-030 SHALL: IdEx_MemWrite=1, MemWb_MemRead=1, IdExRt=00110, MemWbRd=00110 -> Stall=1; same with MemWb_MemRead=0 -> Stall=0.
REQ-031 SHALL: FwdPc=1, all registers 0 -> Flush=1, Stall=0; FwdPc=1 with H1 conditions active -> Flush=1, Stall=0.
REQ-032 SHALL: Ctrl_Branch=1, IdExRt=11101, ExMemRd=11101 -> Stall=1; Ctrl_Branch=0 same values -> Stall=0.
REQ-033 SHALL: Ctrl_Branch=1, MemRb_Reg_wr_control=1, ExMemRs=MemWbRt=10011 -> Stall=1; MemRb_Reg_wr_control=0 -> Stall=0.
REQ-034 SHALL: IdEx_MemRead=1, IdExRt=IfIdRs=00000 -> Stall=0; H1 active with rst_n=0 -> Stall=0, Flush=0.

Source files
------------

// File: rtl/hazard_detection_unit_pkg.sv
// Pipeline constants shared by the hazard detection unit and its comparators.
package hazard_detection_unit_pkg;

  // Width of an architectural register index.
  localparam int unsigned REG_W = 5;

  // Register 0 is hardwired to zero, so it can never carry a data dependency.
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  // Number of register-index compares the unit performs.
  localparam int unsigned NUM_CMP = 9;

  // Slot of each compare in the match vector.
  typedef enum logic [3:0] {
    CMP_H1_RS     = 4'd0,  // IdExRt  vs IfIdRs
    CMP_H1_RT     = 4'd1,  // IdExRt  vs IfIdRt
    CMP_H2_RS     = 4'd2,  // MemWbRd vs IdExRs
    CMP_H2_RT     = 4'd3,  // MemWbRd vs IdExRt
    CMP_H3_EX_RS  = 4'd4,  // ExMemRd vs IdExRs
    CMP_H3_EX_RT  = 4'd5,  // ExMemRd vs IdExRt
    CMP_H3_WB_RS  = 4'd6,  // MemWbRt vs IdExRs
    CMP_H3_WB_RT  = 4'd7,  // MemWbRt vs IdExRt
    CMP_H4        = 4'd8   // ExMemRs vs MemWbRt
  } cmp_idx_e;

endpackage : hazard_detection_unit_pkg

// File: rtl/hazard_detection_unit_reg_match.sv
// Register-index comparator: true when both indices are equal and not the zero register.
module reg_match
  import hazard_detection_unit_pkg::*;
(
  input  logic [REG_W-1:0] idx_a,
  input  logic [REG_W-1:0] idx_b,
  output logic             match
);

  assign match = (idx_a == idx_b) && (idx_a != ZERO_REG);

endmodule : reg_match

// File: rtl/hazard_detection_unit.sv
// Hazard detection unit: decides one cycle ahead whether the front end stalls or flushes.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IdEx_MemRead,
  input  logic             IdEx_MemWrite,
  input  logic             MemWb_MemRead,
  input  logic             MemRb_Reg_wr_control,
  input  logic             Ctrl_Branch,
  input  logic             FwdPc,
  input  logic [REG_W-1:0] IfIdRs,
  input  logic [REG_W-1:0] IfIdRt,
  input  logic [REG_W-1:0] IdExRs,
  input  logic [REG_W-1:0] IdExRt,
  input  logic [REG_W-1:0] ExMemRd,
  input  logic [REG_W-1:0] ExMemRs,
  input  logic [REG_W-1:0] MemWbRd,
  input  logic [REG_W-1:0] MemWbRt,
  output logic             Stall,
  output logic             Flush
);

  logic [REG_W-1:0] cmp_a [NUM_CMP];
  logic [REG_W-1:0] cmp_b [NUM_CMP];
  logic [NUM_CMP-1:0] m;

  logic h1, h2, h3, h4;
  logic stall_d, stall_q;
  logic flush_d, flush_q;

  // Operand pairs for every register compare.
  assign cmp_a[CMP_H1_RS]    = IdExRt;   assign cmp_b[CMP_H1_RS]    = IfIdRs;
  assign cmp_a[CMP_H1_RT]    = IdExRt;   assign cmp_b[CMP_H1_RT]    = IfIdRt;
  assign cmp_a[CMP_H2_RS]    = MemWbRd;  assign cmp_b[CMP_H2_RS]    = IdExRs;
  assign cmp_a[CMP_H2_RT]    = MemWbRd;  assign cmp_b[CMP_H2_RT]    = IdExRt;
  assign cmp_a[CMP_H3_EX_RS] = ExMemRd;  assign cmp_b[CMP_H3_EX_RS] = IdExRs;
  assign cmp_a[CMP_H3_EX_RT] = ExMemRd;  assign cmp_b[CMP_H3_EX_RT] = IdExRt;
  assign cmp_a[CMP_H3_WB_RS] = MemWbRt;  assign cmp_b[CMP_H3_WB_RS] = IdExRs;
  assign cmp_a[CMP_H3_WB_RT] = MemWbRt;  assign cmp_b[CMP_H3_WB_RT] = IdExRt;
  assign cmp_a[CMP_H4]       = ExMemRs;  assign cmp_b[CMP_H4]       = MemWbRt;

  for (genvar g = 0; g < NUM_CMP; g++) begin : g_cmp
    reg_match u_reg_match (
      .idx_a (cmp_a[g]),
      .idx_b (cmp_b[g]),
      .match (m[g])
    );
  end

  // Hazard terms and next-cycle Stall/Flush; a PC redirect overrides any stall.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned and infers a latch.
    h1      = 1'b0;
    h2      = 1'b0;
    h3      = 1'b0;
    h4      = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;

    h1 = IdEx_MemRead & (m[CMP_H1_RS] | m[CMP_H1_RT]);
    h2 = MemWb_MemRead & (IdEx_MemRead | IdEx_MemWrite)
       & (m[CMP_H2_RS] | m[CMP_H2_RT]);
    h3 = Ctrl_Branch & ((m[CMP_H3_EX_RS] | m[CMP_H3_EX_RT])
       | (MemWb_MemRead & (m[CMP_H3_WB_RS] | m[CMP_H3_WB_RT])));
    h4 = Ctrl_Branch & MemRb_Reg_wr_control & m[CMP_H4];

    stall_d = (h1 | h2 | h3 | h4) & ~FwdPc;
    flush_d = FwdPc;
  end

  // Output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      stall_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign Stall = stall_q;
  assign Flush = flush_q;

endmodule : hazard_detection_unit

// File: tb/tb_hazard_detection_unit.sv
// Directed self-checking bench for the hazard detection unit.
module tb_hazard_detection_unit;

  logic       clk;
  logic       rst_n;
  logic       IdEx_MemRead, IdEx_MemWrite, MemWb_MemRead, MemRb_Reg_wr_control;
  logic       Ctrl_Branch, FwdPc;
  logic [4:0] IfIdRs, IfIdRt, IdExRs, IdExRt, ExMemRd, ExMemRs, MemWbRd, MemWbRt;
  logic       Stall, Flush;

  int pass_cnt  = 0;
  int total_cnt = 0;

  hazard_detection_unit dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .IdEx_MemRead         (IdEx_MemRead),
    .IdEx_MemWrite        (IdEx_MemWrite),
    .MemWb_MemRead        (MemWb_MemRead),
    .MemRb_Reg_wr_control (MemRb_Reg_wr_control),
    .Ctrl_Branch          (Ctrl_Branch),
    .FwdPc                (FwdPc),
    .IfIdRs               (IfIdRs),
    .IfIdRt               (IfIdRt),
    .IdExRs               (IdExRs),
    .IdExRt               (IdExRt),
    .ExMemRd              (ExMemRd),
    .ExMemRs              (ExMemRs),
    .MemWbRd              (MemWbRd),
    .MemWbRt              (MemWbRt),
    .Stall                (Stall),
    .Flush                (Flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    IdEx_MemRead = 0; IdEx_MemWrite = 0; MemWb_MemRead = 0; MemRb_Reg_wr_control = 0;
    Ctrl_Branch = 0; FwdPc = 0;
    IfIdRs = 0; IfIdRt = 0; IdExRs = 0; IdExRt = 0;
    ExMemRd = 0; ExMemRs = 0; MemWbRd = 0; MemWbRt = 0;
  endtask

  // Inputs are already set; clock them in and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b00)
      $display("FAIL reset_idle: Stall=%b Flush=%b, want Stall=0 Flush=0", Stall, Flush);
    else pass_cnt++;
    // Hazard and redirect both present while in reset.
    IdEx_MemRead = 1; IdExRt = 5'b01011; IfIdRt = 5'b01011; FwdPc = 1;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b00)
      $display("FAIL reset_override: Stall=%b Flush=%b, want Stall=0 Flush=0", Stall, Flush);
    else pass_cnt++;
    clear_inputs();
    rst_n = 1;
    step();
  endtask

  task automatic test_load_use();
    clear_inputs();
    IdEx_MemRead = 1; IdExRt = 5'b01011; IfIdRt = 5'b01011;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b10)
      $display("FAIL load_use_rt: Stall=%b Flush=%b, want Stall=1 Flush=0", Stall, Flush);
    else pass_cnt++;
    clear_inputs();
    IdEx_MemRead = 1; IdExRt = 5'b00111; IfIdRs = 5'b00111; IfIdRt = 5'b00001;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b10)
      $display("FAIL load_use_rs: Stall=%b Flush=%b, want Stall=1 Flush=0", Stall, Flush);
    else pass_cnt++;
    // Same registers, but the ID/EX instruction is not a load.
    IdEx_MemRead = 0;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b00)
      $display("FAIL load_use_noload: Stall=%b Flush=%b, want Stall=0 Flush=0", Stall, Flush);
    else pass_cnt++;
  endtask

  task automatic test_mem_op();
    clear_inputs();
    IdEx_MemWrite = 1; MemWb_MemRead = 1; IdExRt = 5'b00110; MemWbRd = 5'b00110;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b10)
      $display("FAIL mem_op_store: Stall=%b Flush=%b, want Stall=1 Flush=0", Stall, Flush);
    else pass_cnt++;
    MemWb_MemRead = 0;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b00)
      $display("FAIL mem_op_noload: Stall=%b Flush=%b, want Stall=0 Flush=0", Stall, Flush);
    else pass_cnt++;
    // Load in ID/EX whose base register IdExRs matches the MEM/WB load.
    clear_inputs();
    IdEx_MemRead = 1; MemWb_MemRead = 1; IdExRs = 5'b10001; MemWbRd = 5'b10001;
    IdExRt = 5'b00010; IfIdRs = 5'b00011; IfIdRt = 5'b00100;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b10)
      $display("FAIL mem_op_rs: Stall=%b Flush=%b, want Stall=1 Flush=0", Stall, Flush);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    clear_inputs();
    FwdPc = 1;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b01)
      $display("FAIL flush_plain: Stall=%b Flush=%b, want Stall=0 Flush=1", Stall, Flush);
    else pass_cnt++;
    IdEx_MemRead = 1; IdExRt = 5'b01011; IfIdRt = 5'b01011;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b01)
      $display("FAIL flush_dominates: Stall=%b Flush=%b, want Stall=0 Flush=1", Stall, Flush);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    clear_inputs();
    Ctrl_Branch = 1; IdExRt = 5'b11101; ExMemRd = 5'b11101;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b10)
      $display("FAIL branch_exmem: Stall=%b Flush=%b, want Stall=1 Flush=0", Stall, Flush);
    else pass_cnt++;
    Ctrl_Branch = 0;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b00)
      $display("FAIL branch_off: Stall=%b Flush=%b, want Stall=0 Flush=0", Stall, Flush);
    else pass_cnt++;
    // Branch operand produced by a load still in MEM/WB.
    clear_inputs();
    Ctrl_Branch = 1; MemWb_MemRead = 1; IdExRs = 5'b01100; MemWbRt = 5'b01100;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b10)
      $display("FAIL branch_memwb: Stall=%b Flush=%b, want Stall=1 Flush=0", Stall, Flush);
    else pass_cnt++;
    MemWb_MemRead = 0;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b00)
      $display("FAIL branch_memwb_noload: Stall=%b Flush=%b, want Stall=0 Flush=0", Stall, Flush);
    else pass_cnt++;
  endtask

  task automatic test_branch_wb();
    clear_inputs();
    Ctrl_Branch = 1; MemRb_Reg_wr_control = 1; ExMemRs = 5'b10011; MemWbRt = 5'b10011;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b10)
      $display("FAIL branch_wb: Stall=%b Flush=%b, want Stall=1 Flush=0", Stall, Flush);
    else pass_cnt++;
    MemRb_Reg_wr_control = 0;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b00)
      $display("FAIL branch_wb_nowr: Stall=%b Flush=%b, want Stall=0 Flush=0", Stall, Flush);
    else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    IdEx_MemRead = 1; IdExRt = 5'b00000; IfIdRs = 5'b00000;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b00)
      $display("FAIL zero_load_use: Stall=%b Flush=%b, want Stall=0 Flush=0", Stall, Flush);
    else pass_cnt++;
    clear_inputs();
    Ctrl_Branch = 1; MemRb_Reg_wr_control = 1;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b00)
      $display("FAIL zero_branch_wb: Stall=%b Flush=%b, want Stall=0 Flush=0", Stall, Flush);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_hazard();
    clear_inputs();
    IdEx_MemRead = 1; IdExRt = 5'b01011; IfIdRt = 5'b01011;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b10)
      $display("FAIL mid_pre: Stall=%b Flush=%b, want Stall=1 Flush=0", Stall, Flush);
    else pass_cnt++;
    rst_n = 0;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b00)
      $display("FAIL mid_reset: Stall=%b Flush=%b, want Stall=0 Flush=0", Stall, Flush);
    else pass_cnt++;
    rst_n = 1;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b10)
      $display("FAIL mid_post: Stall=%b Flush=%b, want Stall=1 Flush=0", Stall, Flush);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // Stall, then flush, then idle on consecutive edges: each output lasts one cycle.
    clear_inputs();
    IdEx_MemRead = 1; IdExRt = 5'b00101; IfIdRs = 5'b00101;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b10)
      $display("FAIL b2b_stall: Stall=%b Flush=%b, want Stall=1 Flush=0", Stall, Flush);
    else pass_cnt++;
    clear_inputs();
    FwdPc = 1;
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b01)
      $display("FAIL b2b_flush: Stall=%b Flush=%b, want Stall=0 Flush=1", Stall, Flush);
    else pass_cnt++;
    clear_inputs();
    step();
    total_cnt++;
    if ({Stall, Flush} !== 2'b00)
      $display("FAIL b2b_idle: Stall=%b Flush=%b, want Stall=0 Flush=0", Stall, Flush);
    else pass_cnt++;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    #2;
    test_reset();
    test_load_use();
    test_mem_op();
    test_flush();
    test_branch();
    test_branch_wb();
    test_zero_reg();
    test_reset_mid_hazard();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_hazard_detection_unit
